// File: rtl/oa211_pkg.sv
// Shared definitions for the oa211_pipe block: mode encodings and the lane-wise
// 2-1-1 gate evaluation used when a transaction is accepted.
package oa211_pkg;

    localparam logic [1:0] MODE_OAI = 2'b00;
    localparam logic [1:0] MODE_OA  = 2'b01;
    localparam logic [1:0] MODE_AOI = 2'b10;
    localparam logic [1:0] MODE_AO  = 2'b11;

    // Widest lane count the evaluation function handles; callers zero-extend their
    // operands to this width and keep only the low lanes of the result.
    localparam int EVAL_W = 64;

    // Lane-wise complex gate. An unknown mode yields an unknown result so that
    // X on the mode input is visible downstream instead of being masked.
    function automatic logic [EVAL_W-1:0] oa211_eval(
        input logic [1:0]        mode,
        input logic [EVAL_W-1:0] a,
        input logic [EVAL_W-1:0] b,
        input logic [EVAL_W-1:0] c,
        input logic [EVAL_W-1:0] d
    );
        logic [EVAL_W-1:0] r;
        case (mode)
            MODE_OAI: r = ~((a | b) & c & d);
            MODE_OA:  r =   (a | b) & c & d;
            MODE_AOI: r = ~((a & b) | c | d);
            MODE_AO:  r =   (a & b) | c | d;
            default:  r = {EVAL_W{1'bx}};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/oa211_pipe_stage.sv
// One pipeline slot: a valid flag plus its data word. The valid flag follows the
// upstream valid whenever the slot is allowed to advance; the data word only
// changes when a real result arrives, so bubbles never disturb stored data.
module oa211_pipe_stage
    import oa211_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v_out,
    output logic [WIDTH-1:0] d_out
);

    // Slot register: advance on load, capture data only alongside a valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out <= 1'b0;
            d_out <= '0;
        end else if (load) begin
            v_out <= v_in;
            if (v_in) begin
                d_out <= d_in;
            end
        end
    end

endmodule

// File: rtl/oa211_pipe.sv
// Vectorised, registered 2-1-1 complex gate (OAI/OA/AOI/AO selected per
// transaction) behind a STAGES-deep valid/ready pipeline. The result is computed
// at acceptance, so later mode changes never touch data already in flight.
// A saturating counter tracks how many results the consumer has taken.
// WIDTH must not exceed EVAL_W from the package.
module oa211_pipe
    import oa211_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] res_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] v_src;
    logic [WIDTH-1:0]  data  [STAGES];
    logic [WIDTH-1:0]  d_src [STAGES];
    logic [WIDTH-1:0]  eval_res;

    assign eval_res = WIDTH'(oa211_eval(mode, EVAL_W'(a), EVAL_W'(b), EVAL_W'(c), EVAL_W'(d)));

    // Advance chain from the output backwards: a slot may move when it is empty
    // or when the slot ahead of it is moving. A running term avoids a
    // self-referencing vector so the chain stays a plain combinational cascade.
    always_comb begin
        logic go;
        adv = '0;
        go  = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go     = ~v[k] | go;
            adv[k] = go;
        end
    end

    // Feed each slot from its predecessor; the first slot takes the fresh result.
    always_comb begin
        v_src    = '0;
        v_src[0] = in_valid;
        d_src[0] = eval_res;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v[k-1];
            d_src[k] = data[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        oa211_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (adv[k]),
            .v_in  (v_src[k]),
            .d_in  (d_src[k]),
            .v_out (v[k]),
            .d_out (data[k])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign y         = data[STAGES-1];

    // Delivered-result counter: clear wins over a same-cycle delivery, and the
    // count holds at its maximum instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (clr_cnt) begin
            res_cnt <= '0;
        end else if (out_valid && out_ready && (res_cnt != CNT_MAX)) begin
            res_cnt <= res_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_oa211_pipe.sv
// Self-checking bench for oa211_pipe. A queue-based reference model tracks every
// accepted transaction, when it must appear at the output and how many results
// have been delivered. Two instances share stimulus: a 16-bit counter copy and a
// 2-bit counter copy for saturation.
module tb_oa211_pipe;

    localparam int W = 4;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } item_t;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         clr_cnt;
    logic [1:0]   mode;
    logic [W-1:0] a, b, c, d;

    logic         in_ready, out_valid;
    logic [W-1:0] y;
    logic [15:0]  res_cnt;

    logic         s_in_ready, s_out_valid;
    logic [W-1:0] s_y;
    logic [1:0]   s_res_cnt;

    item_t q[$];
    int    edge_n    = 0;
    int    last_del  = 0;
    int    cnt_big   = 0;
    int    cnt_small = 0;
    logic  seen_ready;

    int n_checks = 0;
    int n_errors = 0;

    oa211_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .clr_cnt(clr_cnt), .res_cnt(res_cnt)
    );

    oa211_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .mode(mode),
        .a(a), .b(b), .c(c), .d(d), .out_valid(s_out_valid), .out_ready(out_ready),
        .y(s_y), .clr_cnt(clr_cnt), .res_cnt(s_res_cnt)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    // Gate behaviour written from the truth rules: pick the OR-first or AND-first
    // form, then invert for the inverting modes (mode bit 0 clear).
    function automatic logic [W-1:0] model_eval(input logic [1:0] m, input logic [W-1:0] ia,
                                                input logic [W-1:0] ib, input logic [W-1:0] ic,
                                                input logic [W-1:0] id);
        logic [W-1:0] t;
        if (m[1] == 1'b0) t = (ia | ib) & ic & id;
        else              t = (ia & ib) | ic | id;
        return m[0] ? t : ~t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [W-1:0] ia,
                                 input logic [W-1:0] ib, input logic [W-1:0] ic,
                                 input logic [W-1:0] id, input logic ordy, input logic clr);
        in_valid  = v;
        mode      = m;
        a         = ia;
        b         = ib;
        c         = ic;
        d         = id;
        out_ready = ordy;
        clr_cnt   = clr;
    endtask

    // One clock: compare mid-cycle against the model, then advance the model
    // across the rising edge. The oldest item always flows freely, so it shows up
    // S-1 edges after its accept edge, or on the edge its predecessor leaves.
    task automatic step_cycle();
        logic exp_ready, exp_valid, acc, del;
        int   fr;
        @(negedge clk);
        exp_ready = (q.size() < S) || out_ready;
        exp_valid = 1'b0;
        if (q.size() > 0) begin
            fr = q[0].acc + S - 1;
            if (last_del > fr) fr = last_del;
            exp_valid = (edge_n >= fr);
        end
        checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        checkOutput("out_valid_small", 32'(s_out_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("y", 32'(y), 32'(q[0].res));
            checkOutput("y_small", 32'(s_y), 32'(q[0].res));
        end
        checkOutput("res_cnt", 32'(res_cnt), 32'(cnt_big));
        checkOutput("res_cnt_small", 32'(s_res_cnt), 32'(cnt_small));
        seen_ready = in_ready;
        acc = in_valid && exp_ready;
        del = exp_valid && out_ready;
        @(posedge clk);
        edge_n++;
        if (del) begin
            void'(q.pop_front());
            last_del = edge_n;
        end
        if (acc) q.push_back('{res: model_eval(mode, a, b, c, d), acc: edge_n});
        if (clr_cnt) begin
            cnt_big   = 0;
            cnt_small = 0;
        end else if (del) begin
            if (cnt_big < 65535) cnt_big++;
            if (cnt_small < 3)   cnt_small++;
        end
        #1;
    endtask

    task automatic drain_all();
        int n = 0;
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
        while ((q.size() > 0 || out_valid) && n < 40) begin
            step_cycle();
            n++;
        end
        checkOutput("drain_out_valid", 32'(out_valid), 32'(0));
    endtask

    initial begin
        vec_t         vecs[11];
        logic [W-1:0] ta[4], tb_[4], tc[4], td[4];
        logic [1:0]   tm[4];
        logic [W-1:0] y1, y2;
        int           idx, acc_n;

        vecs[0]  = '{2'b00, 4'b1010, 4'b0100, 4'b1111, 4'b1101, 4'b0011};
        vecs[1]  = '{2'b10, 4'b1010, 4'b0100, 4'b1111, 4'b1101, 4'b0000};
        vecs[2]  = '{2'b01, 4'b1010, 4'b0100, 4'b1111, 4'b1101, 4'b1100};
        vecs[3]  = '{2'b11, 4'b1010, 4'b0100, 4'b1111, 4'b1101, 4'b1111};
        vecs[4]  = '{2'b10, 4'b1100, 4'b1010, 4'b0001, 4'b0000, 4'b0110};
        vecs[5]  = '{2'b11, 4'b1100, 4'b1010, 4'b0001, 4'b0000, 4'b1001};
        vecs[6]  = '{2'b00, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1111};
        vecs[7]  = '{2'b00, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b1110};
        vecs[8]  = '{2'b00, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1110};
        vecs[9]  = '{2'b00, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1111};
        vecs[10] = '{2'b00, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1111};

        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset_y", 32'(y), 32'(0));
        checkOutput("reset_res_cnt", 32'(res_cnt), 32'(0));
        checkOutput("reset_in_ready", 32'(in_ready), 32'(1));

        $display("[TB] function table");
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, 1'b1, 1'b0);
            step_cycle();
            applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b0);
            step_cycle();
            checkOutput($sformatf("table%0d_valid", i), 32'(out_valid), 32'(1));
            checkOutput($sformatf("table%0d_y", i), 32'(y), 32'(vecs[i].exp));
        end
        drain_all();

        $display("[TB] streaming 10");
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b1);
        step_cycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                          4'($urandom), 4'($urandom), 1'b1, 1'b0);
            step_cycle();
        end
        drain_all();
        checkOutput("stream_res_cnt", 32'(res_cnt), 32'(10));
        checkOutput("stream_res_cnt_small_sat", 32'(s_res_cnt), 32'(3));

        $display("[TB] reset with results in flight");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'b01, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            step_cycle();
        end
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("midrst_y", 32'(y), 32'(0));
        checkOutput("midrst_res_cnt", 32'(res_cnt), 32'(0));
        q.delete();
        cnt_big   = 0;
        cnt_small = 0;
        @(posedge clk);
        edge_n++;
        last_del = edge_n;
        #1;
        rst = 1'b0;
        checkOutput("midrst_in_ready_next", 32'(in_ready), 32'(1));
        step_cycle();

        $display("[TB] backpressure");
        for (int i = 0; i < 4; i++) begin
            tm[i]  = 2'($urandom_range(0, 3));
            ta[i]  = 4'($urandom);
            tb_[i] = 4'($urandom);
            tc[i]  = 4'($urandom);
            td[i]  = 4'($urandom);
        end
        idx   = 0;
        acc_n = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, tm[idx], ta[idx], tb_[idx], tc[idx], td[idx], 1'b0, 1'b0);
            step_cycle();
            if (i == 2) checkOutput("bp_in_ready_3rd", 32'(seen_ready), 32'(0));
            if (seen_ready) begin
                acc_n++;
                idx++;
            end
        end
        checkOutput("bp_accepts", 32'(acc_n), 32'(2));
        drain_all();

        $display("[TB] mode switch in flight");
        applyStimulus(1'b1, 2'b00, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 1'b1, 1'b0);
        step_cycle();
        applyStimulus(1'b1, 2'b11, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 1'b1, 1'b0);
        step_cycle();
        applyStimulus(1'b0, 2'b01, '0, '0, '0, '0, 1'b1, 1'b0);
        y1 = y;
        step_cycle();
        y2 = y;
        checkOutput("mode_first_oai", 32'(y1), 32'(4'b0100));
        checkOutput("mode_second_ao", 32'(y2), 32'(4'b1011));
        drain_all();

        $display("[TB] counter edges");
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b1);
        step_cycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b10, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0);
            step_cycle();
        end
        drain_all();
        checkOutput("cnt_five", 32'(res_cnt), 32'(5));
        checkOutput("cnt_small_sat", 32'(s_res_cnt), 32'(3));
        applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0101, 4'b1111, 4'b1111, 1'b0, 1'b0);
        step_cycle();
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
        step_cycle();
        applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, 1'b1);
        step_cycle();
        checkOutput("clr_with_deliver", 32'(res_cnt), 32'(0));
        checkOutput("clr_with_deliver_small", 32'(s_res_cnt), 32'(0));
        drain_all();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                          4'($urandom), 4'($urandom), 4'($urandom),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            step_cycle();
        end
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
